quasi_oam_dma: RTL and testbench



---
 rtl/quasi_oam_dma_if.sv | 25 ++
 rtl/quasi_oam_dma.sv | 111 +++++++++++
 tb/tb_quasi_oam_dma.sv | 256 +++++++++++++++++++++++++
 3 files changed

// File: rtl/quasi_oam_dma_if.sv
// Core-side and system-bus-side signal bundle for the sprite DMA.
// slave is the controller's view; master is the environment's view.
interface quasi_oam_dma_if;
   logic        cpuRequestWrite;
   logic [15:0] cpuRqAddress;
   logic [7:0]  cpuDataOut;
   logic        cpuHalt;
   logic        busRequestWrite;
   logic [15:0] busRqAddress;
   logic [7:0]  busDataOut;
   logic [7:0]  busDataIn;
   logic        dmaActive;

   modport slave (
      input  cpuRequestWrite, cpuRqAddress, cpuDataOut, busDataIn,
      output cpuHalt, busRequestWrite, busRqAddress, busDataOut,
      output dmaActive
   );

   modport master (
      output cpuRequestWrite, cpuRqAddress, cpuDataOut, busDataIn,
      input  cpuHalt, busRequestWrite, busRqAddress, busDataOut,
      input  dmaActive
   );
endinterface

// File: rtl/quasi_oam_dma.sv
// Sprite OAM DMA: a write to DMA_REG copies page $XX00-$XXFF to OAM_PORT.
// QUASI_OAM_DMA_ALIGN_EN adds the parity-driven ALIGN cycle after HALT.
module quasi_oam_dma #(
   parameter logic [15:0] DMA_REG  = 16'h4014,
   parameter logic [15:0] OAM_PORT = 16'h2004
) (
   input  logic             clk,
   input  logic             reset,
   quasi_oam_dma_if.slave   io
);
   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      HALT  = 3'd1,
      ALIGN = 3'd2,
      READ  = 3'd3,
      WRITE = 3'd4
   } state_e;

   state_e     state_q, state_d;
   logic [7:0] page_q, page_d;
   logic [7:0] index_q, index_d;
   logic       start;

`ifdef QUASI_OAM_DMA_ALIGN_EN
   logic parity_q, parity_d;

   assign parity_d = ~parity_q;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) parity_q <= 1'b0;
      else       parity_q <= parity_d;
   end
`endif

   assign start = (state_q == IDLE) && io.cpuRequestWrite &&
                  (io.cpuRqAddress == DMA_REG);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= IDLE;
         page_q  <= 8'h00;
         index_q <= 8'h00;
      end else begin
         state_q <= state_d;
         page_q  <= page_d;
         index_q <= index_d;
      end
   end

   always_comb begin
      state_d = state_q;
      page_d  = page_q;
      index_d = index_q;
      unique case (state_q)
         IDLE: begin
            if (start) begin
               page_d  = io.cpuDataOut;
               index_d = 8'h00;
               state_d = HALT;
            end
         end
         HALT: begin
`ifdef QUASI_OAM_DMA_ALIGN_EN
            state_d = parity_q ? ALIGN : READ;
`else
            state_d = READ;
`endif
         end
`ifdef QUASI_OAM_DMA_ALIGN_EN
         ALIGN: state_d = READ;
`endif
         READ:  state_d = WRITE;
         WRITE: begin
            // Exit on the last index so index never wraps mid-transfer
            if (index_q == 8'hFF) begin
               state_d = IDLE;
            end else begin
               index_d = index_q + 8'd1;
               state_d = READ;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      io.busRequestWrite = io.cpuRequestWrite;
      io.busRqAddress    = io.cpuRqAddress;
      io.busDataOut      = io.cpuDataOut;
      io.cpuHalt         = (state_q != IDLE);
      io.dmaActive       = (state_q != IDLE);
      unique case (state_q)
         HALT, ALIGN: begin
            io.busRequestWrite = 1'b0;
            io.busRqAddress    = {page_q, 8'h00};
            io.busDataOut      = 8'h00;
         end
         READ: begin
            io.busRequestWrite = 1'b0;
            io.busRqAddress    = {page_q, index_q};
            io.busDataOut      = 8'h00;
         end
         WRITE: begin
            io.busRequestWrite = 1'b1;
            io.busRqAddress    = OAM_PORT;
            io.busDataOut      = io.busDataIn;
         end
         default: ;
      endcase
   end
endmodule

// File: tb/tb_quasi_oam_dma.sv
// Randomized bench for quasi_oam_dma against a page-copy memory model.
// Expected transfer length follows the free-running parity at the HALT cycle.
module tb_quasi_oam_dma;
`ifdef QUASI_OAM_DMA_ALIGN_EN
   localparam bit ALIGN_EN = 1'b1;
`else
   localparam bit ALIGN_EN = 1'b0;
`endif
   localparam logic [15:0] OAM = 16'h2004;

   logic clk = 1'b0;
   logic reset = 1'b1;
   logic tb_par;
   logic [7:0] mem [0:65535];
   int errors = 0;
   int checks = 0;

   quasi_oam_dma_if dif();

   quasi_oam_dma dut (
      .clk   (clk),
      .reset (reset),
      .io    (dif)
   );

   always #5 clk = ~clk;

   // One-cycle read latency system memory
   always @(posedge clk) dif.busDataIn <= mem[dif.busRqAddress];

   // Reference free-running toggle
   always @(posedge clk or posedge reset) begin
      if (reset) tb_par <= 1'b0;
      else       tb_par <= ~tb_par;
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic we, input logic [15:0] a,
                        input logic [7:0] d);
      dif.cpuRequestWrite = we;
      dif.cpuRqAddress    = a;
      dif.cpuDataOut      = d;
   endtask

   task automatic do_transfer(input logic [7:0] page, input int abort_at);
      int hl = 0;
      int nw = 0;
      int expl;
      logic par1 = 1'b0;
      logic [15:0] prev = 16'h0000;
      bit done = 0;
      bit aborted = 0;
      drive(1'b1, 16'h4014, page);
      @(negedge clk);
      checks++;
      if ({dif.busRequestWrite, dif.busRqAddress, dif.busDataOut,
           dif.cpuHalt} !== {1'b1, 16'h4014, page, 1'b0}) begin
         errors++;
         $display("FAIL trig_pass got we=%b a=%h d=%h h=%b want 1 4014 %h 0",
                  dif.busRequestWrite, dif.busRqAddress, dif.busDataOut,
                  dif.cpuHalt, page);
      end
      step();
      for (int c = 1; c <= 600 && !done; c++) begin
         // A stuck core keeps writing DMA_REG; it must be ignored
         if (c == 1) drive(1'b1, 16'h4014, ~page);
         @(negedge clk);
         if (c == 1) begin
            par1 = tb_par;
            checks++;
            if (dif.cpuHalt !== 1'b1) begin
               errors++;
               $display("FAIL halt_rise got %b want 1", dif.cpuHalt);
            end
         end
         if (dif.cpuHalt !== 1'b1) begin
            done = 1;
            checks++;
            if ({dif.dmaActive, dif.busRequestWrite, dif.busRqAddress,
                 dif.busDataOut} !== {1'b0, dif.cpuRequestWrite,
                 dif.cpuRqAddress, dif.cpuDataOut}) begin
               errors++;
               $display("FAIL end_pass got act=%b we=%b a=%h d=%h",
                        dif.dmaActive, dif.busRequestWrite,
                        dif.busRqAddress, dif.busDataOut);
            end
         end else begin
            hl++;
            if (dif.busRequestWrite === 1'b1) begin
               checks++;
               if (dif.busRqAddress !== OAM ||
                   prev !== {page, 8'(nw)} ||
                   dif.busDataOut !== mem[{page, 8'(nw)}]) begin
                  errors++;
                  $display("FAIL oam_wr%0d got a=%h rd=%h d=%h want %h %h %h",
                           nw, dif.busRqAddress, prev, dif.busDataOut,
                           OAM, {page, 8'(nw)}, mem[{page, 8'(nw)}]);
               end
               nw++;
            end else begin
               checks++;
               if (dif.busRqAddress[15:8] !== page ||
                   dif.dmaActive !== 1'b1) begin
                  errors++;
                  $display("FAIL rd_range got a=%h act=%b want page %h",
                           dif.busRqAddress, dif.dmaActive, page);
               end
            end
            prev = dif.busRqAddress;
            if (abort_at > 0 && nw == abort_at) begin
               aborted = 1;
               done = 1;
            end
         end
         if (!done) begin
            step();
            if (dif.cpuHalt !== 1'b1) drive(1'b0, 16'h0300, 8'h11);
         end
      end
      if (!done) begin
         errors++;
         $display("FAIL timeout halt_len=%0d writes=%0d", hl, nw);
      end else if (!aborted) begin
         expl = 513 + ((ALIGN_EN && par1) ? 1 : 0);
         checks++;
         if (hl != expl || nw != 256) begin
            errors++;
            $display("FAIL xfer_len page=%h got len=%0d wr=%0d want %0d 256",
                     page, hl, nw, expl);
         end
      end
   endtask

   task automatic test_reset();
      drive(1'b1, 16'h1234, 8'h5A);
      reset = 1'b1;
      #1;
      checks++;
      if ({dif.busRequestWrite, dif.busRqAddress, dif.busDataOut,
           dif.cpuHalt, dif.dmaActive} !== {1'b1, 16'h1234, 8'h5A,
           1'b0, 1'b0}) begin
         errors++;
         $display("FAIL reset_pass got we=%b a=%h d=%h h=%b act=%b",
                  dif.busRequestWrite, dif.busRqAddress, dif.busDataOut,
                  dif.cpuHalt, dif.dmaActive);
      end
      step();
      step();
      @(negedge clk);
      reset = 1'b0;
      drive(1'b0, 16'h0000, 8'h00);
      step();
   endtask

   task automatic test_non_trigger();
      logic [15:0] addrs [3];
      logic [7:0] d;
      addrs[0] = 16'h4013;
      addrs[1] = 16'h4015;
      addrs[2] = 16'(16'h4016 + $urandom_range(0, 255));
      for (int i = 0; i < 3; i++) begin
         d = 8'($urandom);
         drive(1'b1, addrs[i], d);
         @(negedge clk);
         checks++;
         if ({dif.busRequestWrite, dif.busRqAddress, dif.busDataOut,
              dif.cpuHalt} !== {1'b1, addrs[i], d, 1'b0}) begin
            errors++;
            $display("FAIL nt_pass got we=%b a=%h d=%h h=%b want 1 %h %h 0",
                     dif.busRequestWrite, dif.busRqAddress, dif.busDataOut,
                     dif.cpuHalt, addrs[i], d);
         end
         step();
         drive(1'b0, 16'h0000, 8'h00);
         @(negedge clk);
         checks++;
         if (dif.cpuHalt !== 1'b0 || dif.dmaActive !== 1'b0) begin
            errors++;
            $display("FAIL nt_halt addr=%h got h=%b act=%b want 0 0",
                     addrs[i], dif.cpuHalt, dif.dmaActive);
         end
         step();
      end
   endtask

   task automatic test_page02();
      for (int i = 0; i < 256; i++) mem[{8'h02, 8'(i)}] = 8'(i) ^ 8'hA5;
      do_transfer(8'h02, 0);
      step();
   endtask

   task automatic test_page_ff();
      do_transfer(8'hFF, 0);
      step();
   endtask

   task automatic test_align();
      for (int w = 0; w < 2; w++) begin
         // HALT parity is the complement of the trigger-cycle parity
         if (tb_par == w[0]) step();
         do_transfer(8'($urandom_range(3, 254)), 0);
         step();
      end
   endtask

   task automatic test_reset_mid();
      do_transfer(8'h05, 101);
      step();
      drive(1'b0, 16'h0777, 8'h33);
      reset = 1'b1;
      #1;
      checks++;
      if ({dif.cpuHalt, dif.dmaActive, dif.busRequestWrite,
           dif.busRqAddress, dif.busDataOut} !== {1'b0, 1'b0, 1'b0,
           16'h0777, 8'h33}) begin
         errors++;
         $display("FAIL mid_reset got h=%b act=%b we=%b a=%h d=%h",
                  dif.cpuHalt, dif.dmaActive, dif.busRequestWrite,
                  dif.busRqAddress, dif.busDataOut);
      end
      step();
      @(negedge clk);
      reset = 1'b0;
      for (int i = 0; i < 4; i++) begin
         step();
         @(negedge clk);
         checks++;
         if (dif.cpuHalt !== 1'b0 || dif.busRequestWrite !== 1'b0) begin
            errors++;
            $display("FAIL post_reset got h=%b we=%b want 0 0",
                     dif.cpuHalt, dif.busRequestWrite);
         end
      end
      step();
      do_transfer(8'h06, 0);
      step();
   endtask

   initial begin
      for (int i = 0; i < 65536; i++) mem[i] = 8'($urandom);
      drive(1'b0, 16'h0000, 8'h00);
      test_reset();
      test_non_trigger();
      test_page02();
      test_page_ff();
      test_align();
      test_reset_mid();
      test_non_trigger();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
